block_multicycle_controller: RTL and testbench

Multicycle control FSM for the RV32I core, successor to the single-cycle controller. Sequences fetch, decode, execute, memory and writeback over several clocks so one ALU and one memory port serve the whole datapath. Adds I-type ALU, `jal`, `bne` and illegal-opcode trap support. Adds a memory ready handshake so fetches and data accesses can take wait states.

---
 rtl/block_multicycle_controller.sv | 213 +++++++++++++++++++++
 tb/tb_block_multicycle_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over several clocks with a memory ready handshake and an illegal-opcode trap.
module block_multicycle_controller #(
   parameter int unsigned ALU_CTRL_W  = 3,
   parameter int unsigned MEM_WAIT_EN = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [6:0]            i_op,
   input  logic [2:0]            i_funct3,
   input  logic                  i_funct7,
   input  logic                  i_zero,
   input  logic                  i_mem_ready,
   output logic                  o_mem_req,
   output logic                  o_mem_write,
   output logic                  o_adr_src,
   output logic                  o_ir_write,
   output logic                  o_pc_write,
   output logic                  o_reg_write,
   output logic [1:0]            o_alu_src_a,
   output logic [1:0]            o_alu_src_b,
   output logic [1:0]            o_result_src,
   output logic [1:0]            o_imm_src,
   output logic [ALU_CTRL_W-1:0] o_alu_control,
   output logic                  o_illegal,
   output logic                  o_retire,
   output logic [3:0]            o_state
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECR    = 4'd7,
      S_EXECI    = 4'd8,
      S_ALUWB    = 4'd9,
      S_JAL      = 4'd10,
      S_BRANCH   = 4'd11,
      S_TRAP     = 4'd12
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   state_e     state_q, state_d;
   logic       ready;
   logic [1:0] alu_op;
   logic [1:0] imm_sel;
   logic [2:0] alu_ctrl;

   assign ready = (MEM_WAIT_EN != 0) ? i_mem_ready : 1'b1;

   always_comb begin
      imm_sel = IMM_I;
      case (i_op)
         OP_STORE:  imm_sel = IMM_S;
         OP_BRANCH: imm_sel = IMM_B;
         OP_JAL:    imm_sel = IMM_J;
         default:   imm_sel = IMM_I;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (ready) state_d = S_DECODE;
         S_DECODE: begin
            case (i_op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_JAL:            state_d = S_JAL;
               OP_BRANCH:         state_d = (i_funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
               default:           state_d = S_TRAP;
            endcase
         end
         // Only loads and stores reach MEMADR; opcode bit 5 separates them.
         S_MEMADR:   state_d = i_op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (ready) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_TRAP:     state_d = S_FETCH;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_mem_req    = 1'b0;
      o_mem_write  = 1'b0;
      o_adr_src    = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_reg_write  = 1'b0;
      o_alu_src_a  = 2'b00;
      o_alu_src_b  = 2'b00;
      o_result_src = 2'b00;
      o_imm_src    = 2'b00;
      o_illegal    = 1'b0;
      o_retire     = 1'b0;
      alu_op       = 2'b00;
      case (state_q)
         S_FETCH: begin
            o_mem_req    = 1'b1;
            o_alu_src_b  = 2'b10;
            o_result_src = 2'b10;
            o_ir_write   = ready;
            o_pc_write   = ready;
         end
         S_DECODE: begin
            o_alu_src_a = 2'b01;
            o_alu_src_b = 2'b01;
            o_imm_src   = imm_sel;
         end
         S_MEMADR: begin
            o_alu_src_a = 2'b10;
            o_alu_src_b = 2'b01;
            o_imm_src   = imm_sel;
         end
         S_MEMREAD: begin
            o_mem_req = 1'b1;
            o_adr_src = 1'b1;
         end
         S_MEMWB: begin
            o_result_src = 2'b01;
            o_reg_write  = 1'b1;
            o_retire     = 1'b1;
         end
         S_MEMWRITE: begin
            o_mem_req   = 1'b1;
            o_mem_write = 1'b1;
            o_adr_src   = 1'b1;
            o_retire    = ready;
         end
         S_EXECR: begin
            o_alu_src_a = 2'b10;
            alu_op      = 2'b10;
         end
         S_EXECI: begin
            o_alu_src_a = 2'b10;
            o_alu_src_b = 2'b01;
            alu_op      = 2'b10;
         end
         S_JAL: begin
            o_alu_src_a = 2'b01;
            o_alu_src_b = 2'b10;
            o_pc_write  = 1'b1;
         end
         S_ALUWB: begin
            o_reg_write = 1'b1;
            o_retire    = 1'b1;
         end
         // funct3[0] inverts the zero test: beq takes on zero, bne on non-zero.
         S_BRANCH: begin
            o_alu_src_a = 2'b10;
            alu_op      = 2'b01;
            o_retire    = 1'b1;
            o_pc_write  = i_zero ^ i_funct3[0];
         end
         S_TRAP:  o_illegal = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      alu_ctrl = 3'b000;
      case (alu_op)
         2'b01: alu_ctrl = 3'b001;
         2'b10: begin
            case (i_funct3)
               3'b000:  alu_ctrl = (i_op[5] && i_funct7) ? 3'b001 : 3'b000;
               3'b010:  alu_ctrl = 3'b101;
               3'b110:  alu_ctrl = 3'b011;
               3'b111:  alu_ctrl = 3'b010;
               default: alu_ctrl = 3'b000;
            endcase
         end
         default: alu_ctrl = 3'b000;
      endcase
   end

   assign o_alu_control = ALU_CTRL_W'(alu_ctrl);
   assign o_state       = state_q;

   a_retire_illegal_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(o_retire && o_illegal));
   a_write_needs_req: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      o_mem_write |-> o_mem_req);

endmodule

// File: tb/tb_block_multicycle_controller.sv
// Directed bench for block_multicycle_controller: each stimulus cycle queues the
// expected state/output vector, a negedge monitor pops and compares it.
module tb_block_multicycle_controller;

   logic       clk;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
   logic [2:0] alu_control;
   logic       illegal, retire;
   logic [3:0] state;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [22:0] q_exp[$];
   string       q_name[$];

   block_multicycle_controller #(.ALU_CTRL_W(3), .MEM_WAIT_EN(1)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_op         (op),
      .i_funct3     (funct3),
      .i_funct7     (funct7),
      .i_zero       (zero),
      .i_mem_ready  (mem_ready),
      .o_mem_req    (mem_req),
      .o_mem_write  (mem_write),
      .o_adr_src    (adr_src),
      .o_ir_write   (ir_write),
      .o_pc_write   (pc_write),
      .o_reg_write  (reg_write),
      .o_alu_src_a  (alu_src_a),
      .o_alu_src_b  (alu_src_b),
      .o_result_src (result_src),
      .o_imm_src    (imm_src),
      .o_alu_control(alu_control),
      .o_illegal    (illegal),
      .o_retire     (retire),
      .o_state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector layout: state, req, wr, adr, irw, pcw, rw, srcA, srcB, res, imm, alu, ill, ret
   function automatic logic [22:0] v(input logic [3:0] st, input logic req, input logic wr,
                                     input logic adr, input logic irw, input logic pcw,
                                     input logic rw, input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic [1:0] imm,
                                     input logic [2:0] alu, input logic ill, input logic ret);
      return {st, req, wr, adr, irw, pcw, rw, sa, sb, rs, imm, alu, ill, ret};
   endfunction

   logic [22:0] obs;
   assign obs = {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal, retire};

   always @(negedge clk) begin
      if (q_exp.size() != 0) begin
         logic [22:0] e;
         string       n;
         e = q_exp.pop_front();
         n = q_name.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (state %0d)", n, obs, e, state);
         end
      end
   end

   task automatic step(input string name, input logic [22:0] e);
      q_exp.push_back(e);
      q_name.push_back(name);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_ok();
      mem_ready = 1'b1;
      step("fetch", v(4'd1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 0));
   endtask

   task automatic fetch_wait();
      mem_ready = 1'b0;
      step("fetch_wait", v(4'd1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 0));
   endtask

   task automatic decode(input logic [1:0] imm);
      mem_ready = 1'b0;
      step("decode", v(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, imm, 3'b000, 0, 0));
   endtask

   task automatic aluwb();
      step("aluwb", v(4'd9, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1));
   endtask

   task automatic rtype(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
      op = 7'b0110011; funct3 = f3; funct7 = f7;
      fetch_ok();
      decode(2'b00);
      step("execr", v(4'd7, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, alu, 0, 0));
      aluwb();
   endtask

   task automatic itype(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
      op = 7'b0010011; funct3 = f3; funct7 = f7;
      fetch_ok();
      decode(2'b00);
      step("execi", v(4'd8, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, alu, 0, 0));
      aluwb();
   endtask

   task automatic branch(input logic [2:0] f3, input logic z, input logic pcw);
      op = 7'b1100011; funct3 = f3; funct7 = 1'b0;
      fetch_ok();
      decode(2'b10);
      zero = z;
      step("branch", v(4'd11, 0, 0, 0, 0, pcw, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0, 1));
      zero = 1'b0;
   endtask

   task automatic trap(input logic [1:0] imm);
      step("trap", v(4'd12, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
   endtask

   localparam logic [22:0] ZERO = '0;

   initial begin
      rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7 = 1'b0;
      zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      step("reset", ZERO);
      rst_n = 1'b1;
      step("idle", ZERO);

      // lw, no wait states
      fetch_ok();
      decode(2'b00);
      step("lw_memadr", v(4'd3, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0));
      mem_ready = 1'b1;
      step("lw_memread", v(4'd4, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
      mem_ready = 1'b0;
      step("lw_memwb", v(4'd5, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 0, 1));

      // sw with a fetch wait and three write wait states
      op = 7'b0100011; funct3 = 3'b010;
      fetch_wait();
      fetch_ok();
      decode(2'b01);
      step("sw_memadr", v(4'd3, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000, 0, 0));
      for (int i = 0; i < 3; i++)
         step("sw_wait", v(4'd6, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
      mem_ready = 1'b1;
      step("sw_done", v(4'd6, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1));

      rtype(3'b000, 1'b1, 3'b001);   // sub
      rtype(3'b000, 1'b0, 3'b000);   // add
      rtype(3'b110, 1'b0, 3'b011);   // or
      rtype(3'b010, 1'b0, 3'b101);   // slt
      itype(3'b000, 1'b1, 3'b000);   // addi with bit 30 set stays add
      itype(3'b111, 1'b0, 3'b010);   // andi
      itype(3'b001, 1'b0, 3'b000);   // unsupported funct3 -> add

      // jal
      op = 7'b1101111; funct3 = 3'b000;
      fetch_ok();
      decode(2'b11);
      step("jal", v(4'd10, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 0, 0));
      aluwb();

      branch(3'b000, 1'b0, 1'b0);    // beq not taken
      branch(3'b000, 1'b1, 1'b1);    // beq taken
      branch(3'b001, 1'b0, 1'b1);    // bne taken
      branch(3'b001, 1'b1, 1'b0);    // bne not taken

      // unsupported branch funct3 traps
      op = 7'b1100011; funct3 = 3'b100;
      fetch_ok();
      decode(2'b10);
      trap(2'b00);

      // system opcode traps
      op = 7'b1110011; funct3 = 3'b000;
      fetch_ok();
      decode(2'b00);
      trap(2'b00);

      // async reset while a load waits in MEMREAD
      op = 7'b0000011; funct3 = 3'b010;
      fetch_ok();
      decode(2'b00);
      step("rl_memadr", v(4'd3, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0));
      mem_ready = 1'b0;
      step("rl_memread", v(4'd4, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
      rst_n = 1'b0;
      mem_ready = 1'b1;
      step("rst_async", ZERO);
      step("rst_hold", ZERO);
      rst_n = 1'b1;
      step("rst_idle", ZERO);
      fetch_ok();

      @(negedge clk);
      #1;
      checks++;
      if (q_exp.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q_exp.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
